// File: rtl/fpga_spi_pkg.sv
// Constants, register map and FSM state type shared by the FPGA SPI master and the register slave.
package fpga_spi_pkg;

   localparam int FRAME_BITS = 24;
   localparam int CMD_BITS   = 8;
   localparam int WR_BIT     = 16;

   localparam logic [7:0] ADDR_TRIGSTAT  = 8'h01;
   localparam logic [7:0] ADDR_VERSION   = 8'h04;
   localparam logic [7:0] ADDR_COUNTBASE = 8'h08;
   localparam logic [7:0] ADDR_STRBCOUNT = 8'h0C;
   localparam logic [7:0] ADDR_INTCLOCK  = 8'h18;
   localparam logic [7:0] ADDR_TRIGDELAY = 8'h28;
   localparam logic [7:0] ADDR_TRIGMODE  = 8'h2C;
   localparam logic [7:0] ADDR_SSLOW     = 8'h38;
   localparam logic [7:0] ADDR_SSHIGH    = 8'h3C;
   localparam logic [7:0] ADDR_LAMPEN    = 8'h40;
   localparam logic [7:0] ADDR_OFFSET    = 8'h5C;
   localparam logic [7:0] ADDR_MAXSAT    = 8'h68;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_SHIFT_LO,
      ST_SHIFT_HI,
      ST_HOLD,
      ST_GAP
   } spi_state_e;

   // Wire frame: word address, a reserved zero, the write flag, then 16 data bits.
   function automatic logic [FRAME_BITS-1:0] build_frame(input logic       write,
                                                         input logic [5:0] word_addr,
                                                         input logic [15:0] data);
      return {word_addr, 1'b0, write, data};
   endfunction

endpackage

// File: rtl/fpga_spi_master_if.sv
// Command/response bus between a requester and the FPGA SPI master.
interface fpga_spi_master_if;

   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [7:0]  cmd_addr;
   logic [15:0] cmd_wdata;
   logic        rsp_valid;
   logic [15:0] rsp_rdata;
   logic        busy;

   modport master (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
      input  cmd_ready, rsp_valid, rsp_rdata, busy
   );

   modport slave (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
      output cmd_ready, rsp_valid, rsp_rdata, busy
   );

endinterface

// File: rtl/spi_half_period_timer.sv
// Free-running down-counter that ticks once every HALF_PERIOD cycles; restart realigns the phase.
module spi_half_period_timer #(
   parameter int HALF_PERIOD = 8
) (
   input  logic sys_clk,
   input  logic sys_rst,
   input  logic restart,
   output logic tick
);

   localparam int TW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;

   logic [TW-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q - TW'(1);
      if (restart || (count_q == '0)) begin
         count_d = TW'(HALF_PERIOD - 1);
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         count_q <= TW'(HALF_PERIOD - 1);
      end else begin
         count_q <= count_d;
      end
   end

   assign tick = (count_q == '0);

endmodule

// File: rtl/fpga_spi_master.sv
// Mode-0 SPI master turning one command handshake into a 24-bit register frame and a 16-bit readback.
module fpga_spi_master
   import fpga_spi_pkg::*;
#(
   parameter int HALF_PERIOD = 8,
   parameter int CS_GAP      = 16
) (
   input  logic                sys_clk,
   input  logic                sys_rst,
   fpga_spi_master_if.slave    bus,
   output logic                fpga_clk,
   output logic                fpga_cs,
   output logic                fpga_mosi,
   input  logic                fpga_miso
);

   localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

   spi_state_e            state_q, state_d;
   logic [FRAME_BITS-1:0] tx_q, tx_d;
   logic [15:0]           rx_q, rx_d;
   logic [15:0]           rdata_q, rdata_d;
   logic [4:0]            bit_cnt_q, bit_cnt_d;
   logic [GW-1:0]         gap_q, gap_d;
   logic                  clk_q, clk_d;
   logic                  cs_q, cs_d;
   logic                  mosi_q, mosi_d;
   logic                  busy_q, busy_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic [FRAME_BITS-1:0] frame;
   logic                  restart;
   logic                  tick;
   logic                  unused_addr_bits;

   assign unused_addr_bits = ^bus.cmd_addr[1:0];

   spi_half_period_timer #(
      .HALF_PERIOD (HALF_PERIOD)
   ) u_timer (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .restart (restart),
      .tick    (tick)
   );

   always_comb begin
      frame       = build_frame(bus.cmd_write, bus.cmd_addr[7:2], bus.cmd_wdata);
      state_d     = state_q;
      tx_d        = tx_q;
      rx_d        = rx_q;
      rdata_d     = rdata_q;
      bit_cnt_d   = bit_cnt_q;
      gap_d       = gap_q;
      clk_d       = clk_q;
      cs_d        = cs_q;
      mosi_d      = mosi_q;
      busy_d      = busy_q;
      rsp_valid_d = 1'b0;
      restart     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.cmd_valid) begin
               state_d   = ST_SETUP;
               tx_d      = frame;
               mosi_d    = frame[FRAME_BITS-1];
               cs_d      = 1'b0;
               busy_d    = 1'b1;
               bit_cnt_d = '0;
               restart   = 1'b1;
            end
         end
         // Rising edge: capture miso on the same sys_clk edge that raises fpga_clk.
         ST_SETUP, ST_SHIFT_LO: begin
            if (tick) begin
               state_d = ST_SHIFT_HI;
               clk_d   = 1'b1;
               rx_d    = {rx_q[14:0], fpga_miso};
            end
         end
         ST_SHIFT_HI: begin
            if (tick) begin
               clk_d = 1'b0;
               if (bit_cnt_q == 5'(FRAME_BITS - 1)) begin
                  state_d = ST_HOLD;
                  mosi_d  = 1'b0;
               end else begin
                  state_d   = ST_SHIFT_LO;
                  tx_d      = {tx_q[FRAME_BITS-2:0], 1'b0};
                  mosi_d    = tx_q[FRAME_BITS-2];
                  bit_cnt_d = bit_cnt_q + 5'd1;
               end
            end
         end
         ST_HOLD: begin
            if (tick) begin
               state_d     = ST_GAP;
               cs_d        = 1'b1;
               rsp_valid_d = 1'b1;
               rdata_d     = rx_q;
               gap_d       = GW'(CS_GAP - 1);
            end
         end
         ST_GAP: begin
            if (gap_q == '0) begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
            end else begin
               gap_d = gap_q - GW'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q     <= ST_IDLE;
         tx_q        <= '0;
         rx_q        <= '0;
         rdata_q     <= '0;
         bit_cnt_q   <= '0;
         gap_q       <= '0;
         clk_q       <= 1'b0;
         cs_q        <= 1'b1;
         mosi_q      <= 1'b0;
         busy_q      <= 1'b0;
         rsp_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         tx_q        <= tx_d;
         rx_q        <= rx_d;
         rdata_q     <= rdata_d;
         bit_cnt_q   <= bit_cnt_d;
         gap_q       <= gap_d;
         clk_q       <= clk_d;
         cs_q        <= cs_d;
         mosi_q      <= mosi_d;
         busy_q      <= busy_d;
         rsp_valid_q <= rsp_valid_d;
      end
   end

   assign bus.cmd_ready = (state_q == ST_IDLE) && !sys_rst;
   assign bus.busy      = busy_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rdata_q;
   assign fpga_clk      = clk_q;
   assign fpga_cs       = cs_q;
   assign fpga_mosi     = mosi_q;

endmodule

// File: tb/tb_fpga_spi_master.sv
// Directed bench for fpga_spi_master with a behavioural mode-0 register slave.
module tb_fpga_spi_master;
   import fpga_spi_pkg::*;

   logic sys_clk = 1'b0;
   logic sys_rst = 1'b1;
   logic fpga_clk;
   logic fpga_cs;
   logic fpga_mosi;
   logic fpga_miso = 1'b0;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   fpga_spi_master_if bus ();

   fpga_spi_master #(
      .HALF_PERIOD (8),
      .CS_GAP      (16)
   ) dut (
      .sys_clk   (sys_clk),
      .sys_rst   (sys_rst),
      .bus       (bus),
      .fpga_clk  (fpga_clk),
      .fpga_cs   (fpga_cs),
      .fpga_mosi (fpga_mosi),
      .fpga_miso (fpga_miso)
   );

   always #5 sys_clk = ~sys_clk;

   always @(posedge sys_clk) cyc <= cyc + 1;

   // Slave model: register state, bit counter and last received frame.
   int          s_bits       = 0;
   logic [23:0] s_shift      = '0;
   logic [23:0] s_frame      = '0;
   logic [15:0] s_tx         = '0;
   logic [15:0] reg_intclock = 16'h0006;
   logic [15:0] reg_sslow    = 16'h0005;
   logic        trig_stat    = 1'b0;

   always @(negedge fpga_cs or posedge fpga_clk) begin
      if (!fpga_clk) begin
         s_bits = 0;
      end else if (!fpga_cs) begin
         s_shift = {s_shift[22:0], fpga_mosi};
         s_bits  = s_bits + 1;
         if (s_bits == 8) begin
            case (s_shift[7:2])
               6'h00:   s_tx = {15'd0, trig_stat};
               6'h01:   s_tx = 16'h07E6;
               6'h06:   s_tx = reg_intclock;
               6'h0E:   s_tx = reg_sslow;
               default: s_tx = 16'h0000;
            endcase
         end
         if (s_bits == 24) begin
            s_frame = s_shift;
            if (s_shift[16]) begin
               case (s_shift[23:18])
                  6'h06:   reg_intclock = s_shift[15:0];
                  6'h0E:   reg_sslow    = s_shift[15:0];
                  default: ;
               endcase
            end
         end
      end
   end

   always @(negedge fpga_clk) begin
      int idx;
      if (!fpga_cs && s_bits >= 8 && s_bits < 24) begin
         idx       = 23 - s_bits;
         fpga_miso = s_tx[idx[3:0]];
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic send(input logic w, input logic [7:0] a, input logic [15:0] d,
                       output logic [15:0] rd);
      int n;
      n = 0;
      @(negedge sys_clk);
      while (!bus.cmd_ready && n < 2000) begin
         @(negedge sys_clk);
         n++;
      end
      bus.cmd_valid = 1'b1;
      bus.cmd_write = w;
      bus.cmd_addr  = a;
      bus.cmd_wdata = d;
      @(negedge sys_clk);
      bus.cmd_valid = 1'b0;
      bus.cmd_write = ~w;
      bus.cmd_addr  = ~a;
      bus.cmd_wdata = ~d;
      check_eq("accept_busy", 32'(bus.busy), 32'd1);
      check_eq("accept_cs", 32'(fpga_cs), 32'd0);
      n = 0;
      while (!bus.rsp_valid && n < 1000) begin
         @(negedge sys_clk);
         n++;
      end
      check_eq("rsp_seen", 32'(bus.rsp_valid), 32'd1);
      check_eq("rise_edges", 32'(s_bits), 32'd24);
      rd = bus.rsp_rdata;
      $display("frame w=%0d addr=0x%02h wdata=0x%04h wire=0x%06h rdata=0x%04h",
               w, a, d, s_frame, rd);
   endtask

   initial begin
      logic [15:0] rd;
      int acc_cyc, fall1, rise1, rv1, rdy1, fall2, rv_cnt, n;
      logic prev_cs, prev_rdy;

      bus.cmd_valid = 1'b0;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = '0;
      bus.cmd_wdata = '0;

      repeat (3) @(negedge sys_clk);
      check_eq("rst_ready", 32'(bus.cmd_ready), 32'd0);
      check_eq("rst_busy", 32'(bus.busy), 32'd0);
      check_eq("rst_cs", 32'(fpga_cs), 32'd1);
      check_eq("rst_clk", 32'(fpga_clk), 32'd0);
      check_eq("rst_mosi", 32'(fpga_mosi), 32'd0);
      check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check_eq("rst_rdata", 32'(bus.rsp_rdata), 32'd0);
      sys_rst = 1'b0;
      @(negedge sys_clk);
      check_eq("ready_after_rst", 32'(bus.cmd_ready), 32'd1);

      send(1'b0, ADDR_VERSION, 16'h0000, rd);
      check_eq("version_rdata", 32'(rd), 32'h07E6);
      check_eq("version_cmd_byte", 32'(s_frame[23:16]), 32'h04);

      send(1'b1, ADDR_INTCLOCK, 16'h1234, rd);
      check_eq("wr_old_value", 32'(rd), 32'h0006);
      check_eq("wr_wire_frame", 32'(s_frame), 32'h191234);
      check_eq("wr_slave_reg", 32'(reg_intclock), 32'h1234);
      send(1'b0, ADDR_INTCLOCK, 16'h0000, rd);
      check_eq("rd_back", 32'(rd), 32'h1234);

      send(1'b1, 8'h1B, 16'hABCD, rd);
      check_eq("mask_cmd_byte", 32'(s_frame[23:16]), 32'h19);
      check_eq("mask_slave_reg", 32'(reg_intclock), 32'hABCD);
      check_eq("mask_old_value", 32'(rd), 32'h1234);

      // Timing with cmd_valid held across two frames; the second one reads INTCLOCK.
      n = 0;
      @(negedge sys_clk);
      while (!bus.cmd_ready && n < 2000) begin
         @(negedge sys_clk);
         n++;
      end
      bus.cmd_valid = 1'b1;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = ADDR_VERSION;
      bus.cmd_wdata = 16'h0000;
      acc_cyc  = cyc;
      fall1    = -1;
      rise1    = -1;
      rv1      = -1;
      rdy1     = -1;
      fall2    = -1;
      rv_cnt   = 0;
      prev_cs  = 1'b1;
      prev_rdy = 1'b1;
      for (int i = 0; i < 1000 && fall2 < 0; i++) begin
         @(negedge sys_clk);
         if (i == 0) bus.cmd_addr = ADDR_INTCLOCK;
         if (prev_cs && !fpga_cs) begin
            if (fall1 < 0) fall1 = cyc;
            else           fall2 = cyc;
         end
         if (!prev_cs && fpga_cs && rise1 < 0) rise1 = cyc;
         if (bus.rsp_valid) begin
            rv_cnt++;
            if (rv1 < 0) rv1 = cyc;
         end
         if (!prev_rdy && bus.cmd_ready && rdy1 < 0) rdy1 = cyc;
         prev_cs  = fpga_cs;
         prev_rdy = bus.cmd_ready;
      end
      bus.cmd_valid = 1'b0;
      check_eq("t_cs_fall", 32'(fall1 - acc_cyc), 32'd1);
      check_eq("t_cs_rise", 32'(rise1 - fall1), 32'd392);
      check_eq("t_rsp_valid", 32'(rv1 - fall1), 32'd392);
      check_eq("t_rsp_count", 32'(rv_cnt), 32'd1);
      check_eq("t_ready", 32'(rdy1 - fall1), 32'd408);
      check_eq("t_second_fall", 32'(fall2 - fall1), 32'd409);
      n = 0;
      while (!bus.cmd_ready && n < 1000) begin
         @(negedge sys_clk);
         n++;
      end
      check_eq("b2b_second_rdata", 32'(bus.rsp_rdata), 32'hABCD);
      $display("timing fall=%0d rise=%0d rsp=%0d ready=%0d fall2=%0d", fall1, rise1, rv1, rdy1, fall2);

      // Reset during bit 10 of a write to SSLOW.
      @(negedge sys_clk);
      bus.cmd_valid = 1'b1;
      bus.cmd_write = 1'b1;
      bus.cmd_addr  = ADDR_SSLOW;
      bus.cmd_wdata = 16'h1111;
      @(negedge sys_clk);
      bus.cmd_valid = 1'b0;
      n = 0;
      while (s_bits < 10 && n < 1000) begin
         @(negedge sys_clk);
         n++;
      end
      check_eq("abort_bit10", 32'(s_bits), 32'd10);
      sys_rst = 1'b1;
      @(negedge sys_clk);
      check_eq("abort_cs", 32'(fpga_cs), 32'd1);
      check_eq("abort_clk", 32'(fpga_clk), 32'd0);
      check_eq("abort_mosi", 32'(fpga_mosi), 32'd0);
      check_eq("abort_busy", 32'(bus.busy), 32'd0);
      check_eq("abort_rdata", 32'(bus.rsp_rdata), 32'd0);
      sys_rst = 1'b0;
      rv_cnt = 0;
      for (int i = 0; i < 500; i++) begin
         @(negedge sys_clk);
         if (bus.rsp_valid) rv_cnt++;
      end
      check_eq("abort_no_rsp", 32'(rv_cnt), 32'd0);
      check_eq("abort_slave_reg", 32'(reg_sslow), 32'h0005);
      send(1'b0, ADDR_SSLOW, 16'h0000, rd);
      check_eq("abort_readback", 32'(rd), 32'h0005);

      trig_stat = 1'b1;
      send(1'b0, ADDR_TRIGSTAT, 16'h0000, rd);
      check_eq("trig_set", 32'(rd), 32'h0001);
      check_eq("trig_cmd_byte", 32'(s_frame[23:16]), 32'h00);
      trig_stat = 1'b0;
      send(1'b0, ADDR_TRIGSTAT, 16'h0000, rd);
      check_eq("trig_cleared", 32'(rd), 32'h0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
